// File: rtl/kbuf_pkg.sv
// Shared helpers for the ping-pong kernel buffer: safe address-width function
// and tap-count arithmetic.
package kbuf_pkg;

   localparam int KSIZE_DFLT = 3;
   localparam int KTAPS_DFLT = KSIZE_DFLT * KSIZE_DFLT;

   // Never returns less than one bit, so a two-entry space still gets a counter.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int ktaps(input int ksize);
      return ksize * ksize;
   endfunction

endpackage

// File: rtl/kbuf_bank.sv
// One weight bank: KTAPS independent DEPTH x WIDTH arrays, a single write port
// and an unregistered read of every tap at the same address.
module kbuf_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512,
   parameter int KTAPS = 9,
   parameter int AW    = 9,
   parameter int TW    = 4
) (
   input  logic                   i_aclk,
   input  logic                   wr_en,
   input  logic [TW-1:0]          wr_tap,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [AW-1:0]          rd_addr,
   output logic [KTAPS*WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [KTAPS][DEPTH];

   always_ff @(posedge i_aclk) begin
      if (wr_en) mem[wr_tap][wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned t = 0; t < KTAPS; t++) rd_data[t*WIDTH +: WIDTH] = mem[t][rd_addr];
   end

endmodule

// File: rtl/kernel_buffer_pingpong.sv
// Ping-pong KSIZE x KSIZE x DEPTH weight buffer fed by an AXI4-Stream slave.
// Optional framing check on i_tlast is enabled with `define KBUF_TLAST_CHECK_EN.
module kernel_buffer_pingpong
   import kbuf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512,
   parameter int KSIZE = 3
) (
   input  logic                               i_aclk,
   input  logic                               i_aresetn,
   input  logic                               i_tvalid,
   output logic                               o_tready,
   input  logic [WIDTH-1:0]                   i_tdata,
   input  logic                               i_tlast,
   input  logic [clog2_safe(DEPTH)-1:0]       i_sel,
   input  logic                               i_release,
   output logic                               o_buf_valid,
   output logic [ktaps(KSIZE)*WIDTH-1:0]      o_buf,
   output logic                               o_tlast_err
);

   localparam int KTAPS = ktaps(KSIZE);
   localparam int AW    = clog2_safe(DEPTH);
   localparam int TW    = clog2_safe(KTAPS);

   logic [1:0]             full, full_nxt;
   logic                   wr_bank, rd_bank;
   logic [TW-1:0]          tap_cnt;
   logic [AW-1:0]          addr_cnt;
   logic                   accept, last_beat, release_ok;
   logic                   early_last, missing_last;
   logic [KTAPS*WIDTH-1:0] rd0, rd1;

   assign o_tready    = !full[wr_bank];
   assign o_buf_valid = full[rd_bank];

   always_comb begin
      accept     = i_tvalid && o_tready;
      last_beat  = (tap_cnt == TW'(KTAPS-1)) && (addr_cnt == AW'(DEPTH-1));
      release_ok = i_release && full[rd_bank];
      // Fill and release never target the same bank: a beat needs wr_bank empty.
      full_nxt = full;
      if (accept && last_beat) full_nxt[wr_bank] = 1'b1;
      if (release_ok)          full_nxt[rd_bank] = 1'b0;
   end

`ifdef KBUF_TLAST_CHECK_EN
   assign early_last   = accept && !last_beat && i_tlast;
   assign missing_last = accept && last_beat && !i_tlast;
`else
   logic unused_tlast;
   assign unused_tlast = i_tlast;
   assign early_last   = 1'b0;
   assign missing_last = 1'b0;
`endif

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         full        <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         tap_cnt     <= '0;
         addr_cnt    <= '0;
         o_buf       <= '0;
         o_tlast_err <= 1'b0;
      end else begin
         full <= full_nxt;
         if (release_ok) rd_bank <= ~rd_bank;
         if (accept) begin
            if (last_beat) begin
               wr_bank  <= ~wr_bank;
               tap_cnt  <= '0;
               addr_cnt <= '0;
            end else if (early_last) begin
               tap_cnt  <= '0;
               addr_cnt <= '0;
            end else if (addr_cnt == AW'(DEPTH-1)) begin
               addr_cnt <= '0;
               tap_cnt  <= tap_cnt + TW'(1);
            end else begin
               addr_cnt <= addr_cnt + AW'(1);
            end
         end
         if (early_last || missing_last) o_tlast_err <= 1'b1;
         o_buf <= rd_bank ? rd1 : rd0;
      end
   end

   kbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .KTAPS(KTAPS), .AW(AW), .TW(TW)) u_bank0 (
      .i_aclk  (i_aclk),
      .wr_en   (accept && !wr_bank),
      .wr_tap  (tap_cnt),
      .wr_addr (addr_cnt),
      .wr_data (i_tdata),
      .rd_addr (i_sel),
      .rd_data (rd0)
   );

   kbuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .KTAPS(KTAPS), .AW(AW), .TW(TW)) u_bank1 (
      .i_aclk  (i_aclk),
      .wr_en   (accept && wr_bank),
      .wr_tap  (tap_cnt),
      .wr_addr (addr_cnt),
      .wr_data (i_tdata),
      .rd_addr (i_sel),
      .rd_data (rd1)
   );

endmodule

// File: tb/tb_kernel_buffer_pingpong.sv
// Self-checking bench for kernel_buffer_pingpong (WIDTH=16, DEPTH=4, KSIZE=3)
// against a queue-of-weight-sets reference model.
module tb_kernel_buffer_pingpong;

   localparam int W = 16;
   localparam int D = 4;
   localparam int NT = 9;
   localparam int NB = NT * D;

   typedef logic [W-1:0] set_t [NB];

   logic            i_aclk = 1'b0;
   logic            i_aresetn = 1'b0;
   logic            i_tvalid = 1'b0;
   logic            o_tready;
   logic [W-1:0]    i_tdata = '0;
   logic            i_tlast = 1'b0;
   logic [1:0]      i_sel = '0;
   logic            i_release = 1'b0;
   logic            o_buf_valid;
   logic [NT*W-1:0] o_buf;
   logic            o_tlast_err;

   kernel_buffer_pingpong #(.WIDTH(W), .DEPTH(D), .KSIZE(3)) dut (
      .i_aclk      (i_aclk),
      .i_aresetn   (i_aresetn),
      .i_tvalid    (i_tvalid),
      .o_tready    (o_tready),
      .i_tdata     (i_tdata),
      .i_tlast     (i_tlast),
      .i_sel       (i_sel),
      .i_release   (i_release),
      .o_buf_valid (o_buf_valid),
      .o_buf       (o_buf),
      .o_tlast_err (o_tlast_err)
   );

   always #5 i_aclk = ~i_aclk;

   // Reference model: FIFO of completed sets (oldest = the one being read).
   set_t            sets[$];
   set_t            cur;
   int              cnt = 0;
   bit              err = 0;
   bit              exp_buf_known;
   logic [NT*W-1:0] exp_buf;
   int              nerr = 0;
   int              nchecks = 0;

   function automatic bit exp_ready();
      return sets.size() < 2;
   endfunction

   function automatic bit exp_valid();
      return sets.size() > 0;
   endfunction

   // Beat k of a set lands in tap k/DEPTH at address k%DEPTH.
   task automatic step(input bit v, input logic [W-1:0] d, input bit last,
                       input bit rel, input logic [1:0] sel);
      bit acc, r;
      i_tvalid = v; i_tdata = d; i_tlast = last; i_release = rel; i_sel = sel;
      acc = v && exp_ready();
      r = rel && exp_valid();
      exp_buf_known = exp_valid();
      exp_buf = '0;
      if (exp_buf_known)
         for (int t = 0; t < NT; t++) exp_buf[t*W +: W] = sets[0][t*D + int'(sel)];
      @(posedge i_aclk); #1;
      if (r) void'(sets.pop_front());
      if (acc) begin
         cur[cnt] = d;
         if (cnt == NB-1) begin
            sets.push_back(cur);
            cnt = 0;
`ifdef KBUF_TLAST_CHECK_EN
            if (!last) err = 1;
`endif
         end
`ifdef KBUF_TLAST_CHECK_EN
         else if (last) begin
            cnt = 0;
            err = 1;
         end
`endif
         else cnt++;
      end
      i_tvalid = 0; i_tlast = 0; i_release = 0;
   endtask

   task automatic model_reset();
      sets.delete();
      cnt = 0;
      err = 0;
   endtask

   task automatic test_reset();
      nchecks++;
      if (o_tready !== 1'b1 || o_buf_valid !== 1'b0) begin
         nerr++; $display("FAIL reset_flags: ready=%b valid=%b want 1 0", o_tready, o_buf_valid);
      end
      nchecks++;
      if (o_buf !== '0 || o_tlast_err !== 1'b0) begin
         nerr++; $display("FAIL reset_outputs: buf=%h err=%b want 0 0", o_buf, o_tlast_err);
      end
   endtask

   task automatic test_fill_one();
      for (int i = 0; i < NB; i++) begin
         nchecks++;
         if (o_tready !== 1'b1) begin
            nerr++; $display("FAIL fill1_ready beat %0d: got %b want 1", i, o_tready);
         end
         step(1, W'(i), i == NB-1, 0, 2);
      end
      nchecks++;
      if (o_buf_valid !== 1'b1 || o_tready !== 1'b1) begin
         nerr++; $display("FAIL fill1_flags: valid=%b ready=%b want 1 1", o_buf_valid, o_tready);
      end
      step(0, 0, 0, 0, 2);
      nchecks++;
      if (o_buf !== exp_buf || o_buf[4*W +: W] !== 16'd18) begin
         nerr++; $display("FAIL fill1_data: got %h want %h (tap11=18)", o_buf, exp_buf);
      end
   endtask

   task automatic test_fill_two_hold();
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 2*NB; i++) step(1, W'(i), (i % NB) == NB-1, 0, 1);
      nchecks++;
      if (o_tready !== 1'b0 || o_buf_valid !== 1'b1) begin
         nerr++; $display("FAIL hold_flags: ready=%b valid=%b want 0 1", o_tready, o_buf_valid);
      end
      step(0, 0, 0, 0, 1);
      nchecks++;
      if (o_buf !== exp_buf || o_buf[0 +: W] !== 16'd1) begin
         nerr++; $display("FAIL hold_data: got %h want %h (tap00=1)", o_buf, exp_buf);
      end
   endtask

   task automatic test_release_swap();
      step(0, 0, 0, 1, 1);
      nchecks++;
      if (o_buf_valid !== 1'b1 || o_tready !== 1'b1) begin
         nerr++; $display("FAIL swap_flags: valid=%b ready=%b want 1 1", o_buf_valid, o_tready);
      end
      step(0, 0, 0, 0, 1);
      nchecks++;
      if (o_buf !== exp_buf || o_buf[0 +: W] !== 16'd37 || o_buf[8*W +: W] !== 16'd69) begin
         nerr++; $display("FAIL swap_data: got %h want %h (tap00=37 tap22=69)", o_buf, exp_buf);
      end
   endtask

   task automatic test_release_empty();
      step(0, 0, 0, 1, 0);
      nchecks++;
      if (o_buf_valid !== 1'b0 || o_tready !== 1'b1) begin
         nerr++; $display("FAIL rel_empty: valid=%b ready=%b want 0 1", o_buf_valid, o_tready);
      end
      step(0, 0, 0, 1, 0);
      nchecks++;
      if (o_buf_valid !== 1'b0 || o_tready !== 1'b1) begin
         nerr++; $display("FAIL rel_ignored: valid=%b ready=%b want 0 1", o_buf_valid, o_tready);
      end
      for (int i = 0; i < NB; i++) step(1, W'($urandom), i == NB-1, 0, 3);
      step(0, 0, 0, 0, 3);
      nchecks++;
      if (o_buf_valid !== 1'b1 || o_buf !== exp_buf) begin
         nerr++; $display("FAIL refill: valid=%b buf=%h want 1 %h", o_buf_valid, o_buf, exp_buf);
      end
   endtask

   task automatic test_release_with_final();
      for (int i = 0; i < NB; i++) step(1, W'($urandom), i == NB-1, i == NB-1, 0);
      nchecks++;
      if (o_buf_valid !== 1'b1 || o_tready !== 1'b1 || sets.size() != 1) begin
         nerr++; $display("FAIL rel_final_flags: valid=%b ready=%b want 1 1", o_buf_valid, o_tready);
      end
      step(0, 0, 0, 0, 2);
      nchecks++;
      if (o_buf !== exp_buf) begin
         nerr++; $display("FAIL rel_final_data: got %h want %h", o_buf, exp_buf);
      end
   endtask

   task automatic test_reset_midfill();
      for (int i = 0; i < 20; i++) step(1, W'($urandom), 0, 0, 0);
      i_aresetn = 0;
      #2;
      model_reset();
      nchecks++;
      if (o_tready !== 1'b1 || o_buf_valid !== 1'b0 || o_tlast_err !== 1'b0) begin
         nerr++; $display("FAIL async_reset: ready=%b valid=%b err=%b want 1 0 0", o_tready, o_buf_valid, o_tlast_err);
      end
      @(posedge i_aclk); #1;
      i_aresetn = 1;
      for (int i = 0; i < NB; i++) step(1, W'($urandom), i == NB-1, 0, 1);
      step(0, 0, 0, 0, 1);
      nchecks++;
      if (o_buf_valid !== 1'b1 || o_buf !== exp_buf) begin
         nerr++; $display("FAIL reload: valid=%b buf=%h want 1 %h", o_buf_valid, o_buf, exp_buf);
      end
   endtask

`ifdef KBUF_TLAST_CHECK_EN
   task automatic test_tlast();
      for (int k = 0; k < 2 && o_buf_valid; k++) step(0, 0, 0, 1, 0);
      for (int i = 0; i <= 10; i++) step(1, W'($urandom), i == 10, 0, 0);
      nchecks++;
      if (o_tlast_err !== 1'b1 || o_buf_valid !== 1'b0) begin
         nerr++; $display("FAIL tlast_early: err=%b valid=%b want 1 0", o_tlast_err, o_buf_valid);
      end
      for (int i = 0; i < NB; i++) step(1, W'($urandom), i == NB-1, 0, 2);
      step(0, 0, 0, 0, 2);
      nchecks++;
      if (o_tlast_err !== 1'b1 || o_buf_valid !== 1'b1 || o_buf !== exp_buf) begin
         nerr++; $display("FAIL tlast_restart: err=%b valid=%b buf=%h want 1 1 %h", o_tlast_err, o_buf_valid, o_buf, exp_buf);
      end
   endtask
`endif

   task automatic test_random();
      bit last;
      for (int n = 0; n < 400; n++) begin
`ifdef KBUF_TLAST_CHECK_EN
         last = (cnt == NB-1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 63) == 0);
`else
         last = $urandom_range(0, 1) == 1;
`endif
         step($urandom_range(0, 3) != 0, W'($urandom), last, $urandom_range(0, 15) == 0,
              2'($urandom_range(0, 3)));
         nchecks++;
         if (o_tready !== exp_ready() || o_buf_valid !== exp_valid() || o_tlast_err !== err) begin
            nerr++;
            $display("FAIL rand_flags cyc %0d: ready=%b valid=%b err=%b want %b %b %b",
                     n, o_tready, o_buf_valid, o_tlast_err, exp_ready(), exp_valid(), err);
         end
         if (exp_buf_known) begin
            nchecks++;
            if (o_buf !== exp_buf) begin
               nerr++; $display("FAIL rand_data cyc %0d: got %h want %h", n, o_buf, exp_buf);
            end
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge i_aclk);
      #1;
      test_reset();
      i_aresetn = 1;
      @(posedge i_aclk); #1;
      test_fill_one();
      test_fill_two_hold();
      test_release_swap();
      test_release_empty();
      test_release_with_final();
      test_reset_midfill();
`ifdef KBUF_TLAST_CHECK_EN
      test_tlast();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
